// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: instruction-memory address/data, the redirect
// request, and the valid/ready output stream toward decode.
//   imem_addr      fetch byte address (fetch unit -> memory)
//   imem_data      instruction word for imem_addr, same cycle (memory -> fetch unit)
//   redirect_valid load redirect_pc as the new fetch PC
//   redirect_pc    redirect target byte address
//   out_valid      FIFO head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_instr      instruction at FIFO head
//   out_pc         byte address of out_instr
interface instr_fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   // fetch unit side
   modport master (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   // memory / decode / branch-resolution side
   modport slave (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, reads the combinational
// instruction memory, and buffers {pc, instr} pairs in a small FIFO toward
// decode. Redirects flush the FIFO; misaligned redirect targets and fetch
// PCs outside the text segment halt fetching until a good redirect or reset.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   bus           instr_fetch_unit_if.master (memory, redirect, decode stream)
//   halted        fetch stopped
//   err_misalign  sticky: misaligned redirect target seen
//   err_range     sticky: fetch PC left the text segment
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_RUN  | fetching: push one instruction per cycle when FIFO has room
// ST_HALT | fetch frozen after an error; buffered entries still drain
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
   parameter logic [31:0] TEXT_LAST = 32'h0040_4000,
   parameter int unsigned DEPTH     = 2
) (
   input  logic                clk,
   input  logic                rst,
   instr_fetch_unit_if.master  bus,
   output logic                halted,
   output logic                err_misalign,
   output logic                err_range
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
   logic [CW-1:0] r_count, w_count_nxt;
   logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
   logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
   logic [31:0]   r_fifo_instr [DEPTH];
   logic [31:0]   r_fifo_pc    [DEPTH];
   logic          r_err_misalign, w_err_misalign_nxt;
   logic          r_err_range, w_err_range_nxt;
   logic          w_in_range;
   logic          w_pop;
   logic          w_push;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_fetch_pc     <= RESET_PC;
         r_count        <= '0;
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
         r_err_misalign <= 1'b0;
         r_err_range    <= 1'b0;
         // cleared so the head reads as zero straight out of reset
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_fifo_instr[i] <= '0;
            r_fifo_pc[i]    <= '0;
         end
      end else begin
         r_state        <= w_state_nxt;
         r_fetch_pc     <= w_fetch_pc_nxt;
         r_count        <= w_count_nxt;
         r_rd_ptr       <= w_rd_ptr_nxt;
         r_wr_ptr       <= w_wr_ptr_nxt;
         r_err_misalign <= w_err_misalign_nxt;
         r_err_range    <= w_err_range_nxt;
         if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.imem_data;
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
         end
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_fetch_pc_nxt     = r_fetch_pc;
      w_count_nxt        = r_count;
      w_rd_ptr_nxt       = r_rd_ptr;
      w_wr_ptr_nxt       = r_wr_ptr;
      w_err_misalign_nxt = r_err_misalign;
      w_err_range_nxt    = r_err_range;
      w_push             = 1'b0;
      w_pop              = 1'b0;
      w_in_range         = (r_fetch_pc >= TEXT_BASE) && (r_fetch_pc <= TEXT_LAST);

      if (bus.redirect_valid) begin
         // flush wins over any push or pop this cycle
         w_count_nxt  = '0;
         w_rd_ptr_nxt = '0;
         w_wr_ptr_nxt = '0;
         if (bus.redirect_pc[1:0] == 2'b00) begin
            w_fetch_pc_nxt = bus.redirect_pc;
            w_state_nxt    = ST_RUN;
         end else begin
            w_err_misalign_nxt = 1'b1;
            w_state_nxt        = ST_HALT;
         end
      end else begin
         w_pop = (r_count != '0) && bus.out_ready;
         if (r_state == ST_RUN) begin
            if (w_in_range) begin
               // a simultaneous pop frees the slot, so a full FIFO still streams
               w_push = (r_count < DEPTH_C) || w_pop;
            end else begin
               w_err_range_nxt = 1'b1;
               w_state_nxt     = ST_HALT;
            end
         end
         if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
         end
         if (w_push) begin
            w_wr_ptr_nxt   = r_wr_ptr + AW'(1);
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
         end
         w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign bus.imem_addr = r_fetch_pc;
   assign bus.out_valid = (r_count != '0);
   assign bus.out_instr = r_fifo_instr[r_rd_ptr];
   assign bus.out_pc    = r_fifo_pc[r_rd_ptr];
   assign halted        = (r_state == ST_HALT);
   assign err_misalign  = r_err_misalign;
   assign err_range     = r_err_range;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized
// redirect/ready/reset traffic, all checked every cycle against a
// queue-based reference model of the fetch stream.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0040_0000;
   localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
   localparam logic [31:0] TEXT_LAST = 32'h0040_4000;
   localparam int          DEPTH     = 2;

   logic clk = 1'b0;
   logic rst;
   logic halted, err_misalign, err_range;

   instr_fetch_unit_if u_if ();

   instr_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .TEXT_BASE (TEXT_BASE),
      .TEXT_LAST (TEXT_LAST),
      .DEPTH     (DEPTH)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (u_if),
      .halted       (halted),
      .err_misalign (err_misalign),
      .err_range    (err_range)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + ((a - TEXT_BASE) >> 2);
   endfunction

   assign u_if.imem_data = mem_word(u_if.imem_addr);

   // reference model
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic        m_halt, m_errm, m_errr;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_step(input logic t_rst, input logic t_rv, input logic [31:0] t_rpc,
                             input logic t_rdy);
      bit do_pop, do_push;
      if (t_rst) begin
         m_q.delete();
         m_pc   = RESET_PC;
         m_halt = 0;
         m_errm = 0;
         m_errr = 0;
      end else if (t_rv) begin
         m_q.delete();
         if (t_rpc % 4 == 0) begin
            m_pc   = t_rpc;
            m_halt = 0;
         end else begin
            m_errm = 1;
            m_halt = 1;
         end
      end else begin
         do_pop  = (m_q.size() > 0) && t_rdy;
         do_push = 0;
         if (!m_halt) begin
            if (m_pc >= TEXT_BASE && m_pc <= TEXT_LAST)
               do_push = (m_q.size() < DEPTH) || do_pop;
            else begin
               m_errr = 1;
               m_halt = 1;
            end
         end
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compare_all();
      check_val("imem_addr", u_if.imem_addr, m_pc);
      check_val("out_valid", {31'b0, u_if.out_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
         check_val("out_pc", u_if.out_pc, m_q[0].pc);
         check_val("out_instr", u_if.out_instr, m_q[0].instr);
      end
      check_val("halted", {31'b0, halted}, {31'b0, m_halt});
      check_val("err_misalign", {31'b0, err_misalign}, {31'b0, m_errm});
      check_val("err_range", {31'b0, err_range}, {31'b0, m_errr});
   endtask

   task automatic do_cycle(input logic t_rst, input logic t_rv, input logic [31:0] t_rpc,
                           input logic t_rdy);
      @(negedge clk);
      rst                 = t_rst;
      u_if.redirect_valid = t_rv;
      u_if.redirect_pc    = t_rpc;
      u_if.out_ready      = t_rdy;
      model_step(t_rst, t_rv, t_rpc, t_rdy);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic run(input int n, input logic t_rdy);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, $urandom, t_rdy);
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] a;
      a = TEXT_BASE + ($urandom_range(0, 32'h1000) << 2);
      case ($urandom_range(0, 5))
         0, 1:    return a;
         2:       return a | 32'($urandom_range(1, 3));
         3:       return TEXT_LAST - 32'($urandom_range(0, 3) * 4);
         4:       return TEXT_LAST + 32'd4;
         default: return 32'h0000_0100;
      endcase
   endfunction

   initial begin
      rst                 = 1'b1;
      u_if.redirect_valid = 1'b0;
      u_if.redirect_pc    = '0;
      u_if.out_ready      = 1'b0;
      m_pc = RESET_PC; m_halt = 0; m_errm = 0; m_errr = 0;

      // reset state, including zeroed head
      do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b1, 1'b1, 32'h0040_0200, 1'b1);
      check_val("rst_out_instr", u_if.out_instr, 32'h0);
      check_val("rst_out_pc", u_if.out_pc, 32'h0);

      // streaming, one per cycle
      run(8, 1'b1);

      // backpressure: two pushes then full
      do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      run(7, 1'b0);
      check_val("bp_imem_addr", u_if.imem_addr, 32'h0040_0008);
      check_val("bp_out_pc", u_if.out_pc, 32'h0040_0000);
      run(6, 1'b1);

      // redirect with entries buffered and ready high
      do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      run(3, 1'b0);
      do_cycle(1'b0, 1'b1, 32'h0040_0100, 1'b1);
      check_val("redir_flush_valid", {31'b0, u_if.out_valid}, 32'h0);
      do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_val("redir_first_pc", u_if.out_pc, 32'h0040_0100);
      run(3, 1'b1);

      // misaligned redirect, then recovery
      do_cycle(1'b0, 1'b1, 32'h0040_0102, 1'b1);
      run(4, 1'b1);
      do_cycle(1'b0, 1'b1, 32'h0040_0000, 1'b1);
      run(4, 1'b1);
      check_val("recover_errm_sticky", {31'b0, err_misalign}, 32'h1);

      // run off the end of the text segment
      do_cycle(1'b0, 1'b1, 32'h0040_3FFC, 1'b1);
      run(6, 1'b1);
      check_val("end_halted", {31'b0, halted}, 32'h1);

      // reset mid-stream with a redirect in the same cycle
      do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      run(4, 1'b1);
      do_cycle(1'b1, 1'b1, 32'h0040_0300, 1'b1);
      check_val("rst_redir_pc", u_if.imem_addr, 32'h0040_0000);
      run(3, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r_rst, r_rv;
         r_rst = ($urandom_range(0, 99) == 0);
         r_rv  = ($urandom_range(0, 7) == 0);
         do_cycle(r_rst, r_rv, r_rv ? rand_target() : $urandom,
                  ($urandom_range(0, 3) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
